// File: rtl/fpu_align_addsub.sv
// fpu_align_addsub: two-stage FP32 add/sub front end (compare/swap/align, then mantissa add/sub).
module fpu_align_addsub (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        is_add_path,
    output logic        carry_out,
    output logic [26:0] mant_out,
    output logic [7:0]  exp_out,
    output logic        sign_out,
    output logic        special_valid,
    output logic [31:0] special_result
);
    logic        a_sign, b_sign, eff_sub, swap;
    logic [7:0]  a_exp, b_exp, l_exp, s_exp, d;
    logic [22:0] a_frac, b_frac;
    logic [26:0] a_mant, b_mant, l_mant, s_mant, s_mask, s_shift;
    logic        a_nan, b_nan, a_inf, b_inf, l_sign;
    logic        c_special;
    logic [31:0] c_special_result;
    logic        s2_load, s1_load;
    logic        s1_valid, s1_eff_sub, s1_sign, s1_special;
    logic [26:0] s1_l, s1_s;
    logic [7:0]  s1_exp;
    logic [31:0] s1_special_result;
    logic        s2_valid, s2_special;
    logic [27:0] sum;
    logic [26:0] diff;
    always_comb begin
        a_sign  = a[31];
        b_sign  = b[31] ^ sub;
        a_exp   = a[30:23];
        b_exp   = b[30:23];
        // exponent-zero operands are flushed: no hidden bit, zero fraction
        a_frac  = (a_exp == 8'd0) ? 23'd0 : a[22:0];
        b_frac  = (b_exp == 8'd0) ? 23'd0 : b[22:0];
        a_mant  = {(a_exp != 8'd0), a_frac, 3'b000};
        b_mant  = {(b_exp != 8'd0), b_frac, 3'b000};
        eff_sub = a[31] ^ b[31] ^ sub;
        swap    = {b_exp, b_frac} > {a_exp, a_frac};
        l_exp   = swap ? b_exp : a_exp;
        s_exp   = swap ? a_exp : b_exp;
        l_mant  = swap ? b_mant : a_mant;
        s_mant  = swap ? a_mant : b_mant;
        l_sign  = swap ? b_sign : a_sign;
        d       = l_exp - s_exp;
        s_mask  = (27'h1 << d[4:0]) - 27'h1;
        s_shift = (d >= 8'd27) ? {26'd0, |s_mant}
                : ((s_mant >> d[4:0]) | {26'd0, |(s_mant & s_mask)});
        a_nan   = (a_exp == 8'hFF) && (a[22:0] != 23'd0);
        b_nan   = (b_exp == 8'hFF) && (b[22:0] != 23'd0);
        a_inf   = (a_exp == 8'hFF) && (a[22:0] == 23'd0);
        b_inf   = (b_exp == 8'hFF) && (b[22:0] == 23'd0);
        c_special = a_nan | b_nan | a_inf | b_inf;
        c_special_result = (a_nan | b_nan | (a_inf & b_inf & eff_sub)) ? 32'h7FC00000
                         : {(a_inf ? a_sign : b_sign), 8'hFF, 23'd0};
    end
    assign s2_load  = ~s2_valid | out_ready;
    assign s1_load  = ~s1_valid | s2_load;
    assign in_ready = ~s1_valid | s2_load;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid          <= 1'b0;
            s1_eff_sub        <= 1'b0;
            s1_sign           <= 1'b0;
            s1_special        <= 1'b0;
            s1_l              <= 27'd0;
            s1_s              <= 27'd0;
            s1_exp            <= 8'd0;
            s1_special_result <= 32'd0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_eff_sub        <= eff_sub;
                s1_sign           <= l_sign;
                s1_special        <= c_special;
                s1_l              <= l_mant;
                s1_s              <= s_shift;
                s1_exp            <= l_exp;
                s1_special_result <= c_special_result;
            end
        end
    end
    // L >= S_shifted by construction, so the difference never borrows
    assign sum  = {1'b0, s1_l} + {1'b0, s1_s};
    assign diff = s1_l - s1_s;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid       <= 1'b0;
            s2_special     <= 1'b0;
            is_add_path    <= 1'b0;
            carry_out      <= 1'b0;
            mant_out       <= 27'd0;
            exp_out        <= 8'd0;
            sign_out       <= 1'b0;
            special_result <= 32'd0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_special     <= s1_special;
                is_add_path    <= ~s1_eff_sub;
                carry_out      <= s1_eff_sub ? 1'b0 : sum[27];
                mant_out       <= s1_eff_sub ? diff : sum[26:0];
                exp_out        <= s1_exp;
                sign_out       <= (s1_eff_sub && diff == 27'd0) ? 1'b0 : s1_sign;
                special_result <= s1_special_result;
            end
        end
    end
    assign out_valid     = s2_valid;
    assign special_valid = s2_valid & s2_special;
endmodule
